alu_seq_dec: RTL



---
 rtl/alu_seq_dec.sv | 93 +++++++++
 1 files changed

// File: rtl/alu_seq_dec.sv
// alu_seq_dec: ALU control decoder with a sequencer that stalls and steps multi-cycle ops
module alu_seq_dec #(
  parameter int MUL_ITERS  = 32,
  parameter int RXOR_ITERS = 8,
  parameter int CNTW       = 6,
  parameter int ENABLE_MUL = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [5:0]      funct,
  input  logic [2:0]      aluop,
  input  logic            flush,
  output logic [3:0]      alucontrol,
  output logic            runxor,
  output logic            illegal,
  output logic            stall,
  output logic            init,
  output logic            step,
  output logic [CNTW-1:0] iter,
  output logic            done,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [CNTW-1:0] RLAST = CNTW'(RXOR_ITERS - 1);
  localparam logic [CNTW-1:0] MLAST = CNTW'(MUL_ITERS - 1);
  if (RXOR_ITERS < 1 || RXOR_ITERS > 2**CNTW || MUL_ITERS < 1 || MUL_ITERS > 2**CNTW) begin : g_bad_iters
    $error("alu_seq_dec: iteration count out of range for CNTW");
  end
  state_t state, nxt;
  logic [CNTW-1:0] cnt, lim;
  logic [3:0] code, dcode;
  logic dill, mc, go, live;
  always_comb begin
    dcode = 4'b0000;
    dill = 1'b0;
    case (aluop)
      3'b000: dcode = 4'b0010;
      3'b001: dcode = 4'b0110;
      3'b011: dcode = 4'b0011;
      3'b100: dcode = 4'b0100;
      3'b101: dcode = 4'b1000;
      3'b110: dcode = 4'b1001;
      default:
        case (funct)
          6'b100000: dcode = 4'b0010;
          6'b100010: dcode = 4'b0110;
          6'b100100: dcode = 4'b0000;
          6'b100101: dcode = 4'b0001;
          6'b101010: dcode = 4'b0111;
          6'b000110: dcode = 4'b0101;
          6'b101101: dcode = 4'b1010;
          6'b011000: {dcode, dill} = (ENABLE_MUL != 0) ? 5'b10110 : 5'b00001;
          default:   dill = 1'b1;
        endcase
    endcase
  end
  assign mc  = dcode[3:1] == 3'b101;
  assign go  = state == IDLE && start && mc && !flush;
  assign lim = code == 4'b1010 ? RLAST : MLAST;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      code  <= 4'b0000;
    end else begin
      state <= nxt;
      cnt   <= (state == RUN && !flush && cnt != lim) ? cnt + 1'b1 : '0;
      code  <= go ? dcode : code;
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = go ? RUN : IDLE;
      RUN:     nxt = flush ? IDLE : (cnt == lim ? DONE : RUN);
      default: nxt = IDLE;
    endcase
  end
  // while reset is held the block looks idle: outputs follow the live decode only
  always_comb begin
    live       = state == IDLE || reset;
    alucontrol = live ? dcode : code;
    illegal    = live && dill;
    runxor     = !reset && (live ? dcode == 4'b1010 : code == 4'b1010);
    init       = !reset && go;
    step       = !reset && state == RUN;
    stall      = init || step;
    iter       = step ? cnt : '0;
    done       = !reset && state == DONE && !flush;
    busy       = !reset && state != IDLE;
  end
endmodule
